// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates the shared 17-bit word-addressed memory bus between the CPU and
// the IOP. All outputs are registered; every owner change passes through one idle TURN cycle
// so tri-state drivers never overlap. MAX_HOLD bounds a grant while the other master waits.
// Optional grant/contention statistics are built when MEM_ARB_STATS_EN is defined; otherwise
// the three counter ports are tied to zero.
module mem_bus_arbiter #(
  parameter int unsigned MAX_HOLD     = 8,
  parameter int unsigned IOP_PRIORITY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        iop_req,
  output logic        cpu_active,
  output logic        iop_active,
  output logic        bus_busy,
  output logic        preempt,
  output logic [15:0] cpu_grant_cnt,
  output logic [15:0] iop_grant_cnt,
  output logic [15:0] contention_cnt
);

  // The hold counter never exceeds MAX_HOLD-1, so clog2(MAX_HOLD) bits are enough.
  localparam int unsigned      HoldW     = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLimit = HoldW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam bit               HoldEn    = (MAX_HOLD != 0);

  typedef enum logic [1:0] {StIdle, StGntCpu, StGntIop, StTurn} state_e;

  state_e           state_q;
  logic [HoldW-1:0] hold_q;
  logic             last_iop_q;  // last owner: 0 = CPU, 1 = IOP
  logic             any_req;
  logic             win_iop;
  logic             own_req;
  logic             oth_req;
  logic             hold_expire;

  // Arbitration winner for a grant leaving IDLE or TURN.
  always_comb begin
    any_req = cpu_req | iop_req;
    if (cpu_req && iop_req) begin
      win_iop = (IOP_PRIORITY != 0) ? 1'b1 : ~last_iop_q;
    end else begin
      win_iop = iop_req;
    end
  end

  // Owner and waiter requests, and MAX_HOLD expiry, while a grant is held.
  always_comb begin
    own_req     = (state_q == StGntIop) ? iop_req : cpu_req;
    oth_req     = (state_q == StGntIop) ? cpu_req : iop_req;
    hold_expire = HoldEn && oth_req && (hold_q == HoldLimit);
  end

  // Ownership FSM with registered enables, busy and preempt pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cpu_active <= 1'b0;
      iop_active <= 1'b0;
      bus_busy   <= 1'b0;
      preempt    <= 1'b0;
      hold_q     <= '0;
      last_iop_q <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state_q)
        StGntCpu, StGntIop: begin
          if (!own_req || hold_expire) begin
            // A release on the expiry cycle is a plain release, so preempt only if still held.
            state_q    <= StTurn;
            cpu_active <= 1'b0;
            iop_active <= 1'b0;
            bus_busy   <= 1'b1;
            preempt    <= own_req;
            hold_q     <= '0;
            last_iop_q <= (state_q == StGntIop);
          end else if (HoldEn && oth_req) begin
            hold_q <= hold_q + HoldW'(1);
          end
        end
        default: begin
          // IDLE and TURN arbitrate identically; requests are sampled, never latched.
          hold_q <= '0;
          if (any_req) begin
            state_q    <= win_iop ? StGntIop : StGntCpu;
            cpu_active <= ~win_iop;
            iop_active <= win_iop;
            bus_busy   <= 1'b1;
          end else begin
            state_q    <= StIdle;
            cpu_active <= 1'b0;
            iop_active <= 1'b0;
            bus_busy   <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic        grant_entry;
  logic [15:0] cpu_cnt_q;
  logic [15:0] iop_cnt_q;
  logic [15:0] cont_cnt_q;

  assign grant_entry = ((state_q == StIdle) || (state_q == StTurn)) && any_req;

  // Saturating grant-entry and contention counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_cnt_q  <= 16'h0;
      iop_cnt_q  <= 16'h0;
      cont_cnt_q <= 16'h0;
    end else begin
      if (grant_entry && !win_iop && (cpu_cnt_q != 16'hFFFF)) begin
        cpu_cnt_q <= cpu_cnt_q + 16'd1;
      end
      if (grant_entry && win_iop && (iop_cnt_q != 16'hFFFF)) begin
        iop_cnt_q <= iop_cnt_q + 16'd1;
      end
      if (cpu_req && iop_req && (cont_cnt_q != 16'hFFFF)) begin
        cont_cnt_q <= cont_cnt_q + 16'd1;
      end
    end
  end

  assign cpu_grant_cnt  = cpu_cnt_q;
  assign iop_grant_cnt  = iop_cnt_q;
  assign contention_cnt = cont_cnt_q;
`else
  assign cpu_grant_cnt  = 16'h0;
  assign iop_grant_cnt  = 16'h0;
  assign contention_cnt = 16'h0;
`endif

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates the single 17-bit word-addressed memory bus between the CPU and the IOP.
- Drives the `active` enables that let each master's tri-stated address, data and write-enable outputs onto the shared bus.
- Guarantees at most one master enabled at any time.
- Inserts one idle turnaround cycle between ownership changes so tri-state drivers never overlap.

Parameters:
- MAX_HOLD, 8: max consecutive granted cycles while the other master waits. 0 = unlimited.
- IOP_PRIORITY, 1: 1 = IOP wins simultaneous requests; 0 = round-robin (last owner loses).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- cpu_req  input  1  CPU requests bus; held high for the whole access/burst
- iop_req  input  1  IOP requests bus; held high for the whole access/burst
- cpu_active  output  1  CPU owns bus (drives CPU address/data/wr enables)
- iop_active  output  1  IOP owns bus (connects to IOP `active`)
- bus_busy  output  1  cpu_active | iop_active | turnaround in progress
- preempt  output  1  one-cycle pulse when owner's grant is revoked by MAX_HOLD
- cpu_grant_cnt  output  16  CPU grant count (see Optional Feature)
- iop_grant_cnt  output  16  IOP grant count (see Optional Feature)
- contention_cnt  output  16  contention cycles (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-high. Reset is the only asynchronous input; all else is synchronous to posedge clock.
- Reset state: state=IDLE; cpu_active=iop_active=bus_busy=preempt=0; hold counter=0; last_owner=CPU; stats counters=0.
- All outputs are registered. No combinational path from req to active.
- States:
  - IDLE -> GNT_CPU or GNT_IOP on the next clock edge when a request is present. Grant latency = 1 cycle after req is sampled high.
  - GNT_CPU: cpu_active=1. GNT_IOP: iop_active=1.
  - TURN: both active=0, bus_busy=1. Lasts exactly 1 cycle, then goes to the arbitration winner, or IDLE if no request.
- Arbitration in IDLE/TURN:
  - Only one req high: that master wins.
  - Both high, IOP_PRIORITY=1: IOP wins.
  - Both high, IOP_PRIORITY=0: the master that is not last_owner wins.
- Release: owner deasserts req -> next edge goes to TURN (never directly IDLE). last_owner updates on entry to TURN.
- Hold counter:
  - Increments each granted cycle while the other req is high; clears on any state change.
  - At hold counter == MAX_HOLD-1 with the other req still high: next edge forces TURN and preempt pulses that cycle.
  - The preempted master must drop its req or accept re-arbitration. Its req still high counts as a new request.
- A request dropped during TURN is ignored; it is not latched.
- Owner's req deasserted on the same cycle MAX_HOLD expires: treat as normal release, preempt=0.
- Invariants:
  - cpu_active & iop_active never both 1.
  - Any change of owner passes through ≥1 cycle with both low.
- Reset mid-grant: both actives drop immediately (asynchronous). The interrupted access is lost; masters re-request after reset.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - cpu_grant_cnt/iop_grant_cnt increment on each entry to GNT_CPU/GNT_IOP.
  - contention_cnt increments each cycle both reqs are high.
  - All three saturate at 16'hFFFF and clear on reset.
- Undefined: the three counter ports are tied to 16'h0 and the counter registers are not instantiated. Arbitration behaviour is identical.

Test Plan:
1. Reset, cpu_req=1 alone → cpu_active=1 one cycle after req sampled. Release → TURN 1 cycle (bus_busy=1, both active 0) → IDLE, bus_busy=0.
2. IOP_PRIORITY=1, cpu_req=iop_req=1 from IDLE → iop_active=1, cpu_active=0. IOP releases → TURN → cpu_active=1.
3. IOP_PRIORITY=0, both reqs held continuously, MAX_HOLD=8 → owner alternates CPU/IOP. Each grant is 8 cycles + 1 TURN; preempt pulses once per switch.
4. MAX_HOLD=8, CPU owns, iop_req rises at cycle 3 of grant → CPU preempted after 8 cycles of contention. Owner drops req on the expiry cycle → preempt=0.
5. Assert reset during GNT_IOP → iop_active=0 in the same cycle, before the clock edge. After release, state=IDLE and all counters=0.
6. MEM_ARB_STATS_EN defined, 3 CPU grants + 2 IOP grants with 5 contention cycles → cpu_grant_cnt=3, iop_grant_cnt=2, contention_cnt=5. Macro undefined → all three read 0.
